dbg_run_ctrl: RTL and testbench

Run-control sequencer for the JTAG debug path. It takes debug commands latched by the JTAG data registers (TCK domain, quasi-static) and gates the CPU clock enable: halt, free-run, single/N-step, hardware breakpoint on the instruction address, and a timed CPU reset pulse. It sits between the JTAG register chain and the clock divider/CPU, and runs on the system clock.

---
 rtl/dbg_run_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dbg_run_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: debug run-control sequencer. Accepts commands from the JTAG
// data registers through a strobe synchronizer and gates the CPU clock enable
// for halt, free-run, N-step, hardware breakpoint and a timed CPU reset pulse.
// Optional feature macro: DBG_CYCLE_COUNTER_EN (enabled-cycle counter on cycle_cnt).
//
// state  | meaning
// -------+---------------------------------------------------------------
// HALT   | CPU clock gated off, waiting for a command
// RUN    | CPU free-running until a breakpoint match or command
// STEP   | CPU enabled for step_left more cycles, then HALT
// BREAK  | stopped on a breakpoint match; bp_hit is set

module dbg_run_ctrl #(
  parameter int PC_WIDTH       = 32,
  parameter int STEP_WIDTH     = 16,
  parameter int CPU_RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_strobe,
  input  logic [3:0]            cmd,
  input  logic [PC_WIDTH-1:0]   cmd_arg,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  cpu_clk_en,
  output logic                  cpu_rst,
  output logic                  halted,
  output logic [1:0]            state,
  output logic                  bp_hit,
  output logic [STEP_WIDTH-1:0] step_left,
  output logic [31:0]           cycle_cnt
);

  localparam int RW = $clog2(CPU_RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(CPU_RST_CYCLES);

  localparam logic [3:0] CMD_HALT      = 4'd1;
  localparam logic [3:0] CMD_RUN       = 4'd2;
  localparam logic [3:0] CMD_STEP      = 4'd3;
  localparam logic [3:0] CMD_SET_BP    = 4'd4;
  localparam logic [3:0] CMD_CLR_BP    = 4'd5;
  localparam logic [3:0] CMD_RESET_CPU = 4'd6;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  bp_en_q, bp_en_d;
  logic [PC_WIDTH-1:0]   bp_addr_q, bp_addr_d;
  logic                  bp_skip_q, bp_skip_d;
  logic                  bp_hit_q, bp_hit_d;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic                  sync1_q, sync2_q, sync3_q;

  logic                  cmd_exec;
  logic                  bp_match;
  logic                  run_like;
  logic [STEP_WIDTH-1:0] step_arg;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= cmd_strobe;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign cmd_exec   = sync2_q & ~sync3_q;
  assign run_like   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign bp_match   = bp_en_q && (pc == bp_addr_q) && !bp_skip_q;
  assign cpu_rst    = (rcnt_q != '0);
  assign cpu_clk_en = run_like && !bp_match && !cpu_rst;
  assign step_arg   = (cmd_arg[STEP_WIDTH-1:0] == '0) ? STEP_WIDTH'(1)
                                                     : cmd_arg[STEP_WIDTH-1:0];

  // Run-control state and breakpoint registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALT;
      step_q    <= '0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      bp_skip_q <= 1'b0;
      bp_hit_q  <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      bp_skip_q <= bp_skip_d;
      bp_hit_q  <= bp_hit_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Next state: automatic transitions first, an accepted command overrides them.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    bp_skip_d = bp_skip_q;
    bp_hit_d  = bp_hit_q;
    rcnt_d    = cpu_rst ? rcnt_q - RW'(1) : rcnt_q;

    // The skip only covers the instruction sitting on the breakpoint address.
    if (bp_skip_q && ((pc != bp_addr_q) || !run_like)) begin
      bp_skip_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (bp_match) begin
          state_d  = ST_BREAK;
          bp_hit_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (bp_match) begin
          state_d  = ST_BREAK;
          bp_hit_d = 1'b1;
        end else if (cpu_clk_en) begin
          step_d = step_q - STEP_WIDTH'(1);
          if (step_q <= STEP_WIDTH'(1)) begin
            state_d = ST_HALT;
          end
        end
      end
      default: ;
    endcase

    if (cmd_exec) begin
      case (cmd)
        CMD_HALT: state_d = ST_HALT;
        CMD_RUN: begin
          if (state_q != ST_RUN) begin
            state_d = ST_RUN;
            if (state_q == ST_BREAK) bp_skip_d = 1'b1;
          end
        end
        CMD_STEP: begin
          state_d = ST_STEP;
          step_d  = step_arg;
          if (state_q == ST_BREAK) bp_skip_d = 1'b1;
        end
        CMD_SET_BP: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        CMD_CLR_BP: begin
          bp_en_d  = 1'b0;
          bp_hit_d = 1'b0;
        end
        CMD_RESET_CPU: begin
          rcnt_d  = RST_LOAD;
          state_d = ST_HALT;
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign bp_hit    = bp_hit_q;
  assign step_left = step_q;

`ifdef DBG_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  // Enabled-cycle counter; a CPU reset restarts the count.
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  // Clear on RESET_CPU wins over counting; wraps naturally at 32 bits.
  always_comb begin
    cyc_d = cyc_q;
    if (cmd_exec && (cmd == CMD_RESET_CPU)) cyc_d = '0;
    else if (cpu_clk_en)                    cyc_d = cyc_q + 32'd1;
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl: stepping, breakpoints with resume,
// CPU reset pulse, strobe edge handling, synchronous reset and cycle counter.

module tb_dbg_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_strobe = 1'b0;
  logic [3:0]  cmd = 4'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        cpu_clk_en;
  logic        cpu_rst;
  logic        halted;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] step_left;
  logic [31:0] cycle_cnt;

  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = 32'd0;

  int tests_run = 0;
  int fails = 0;

`ifdef DBG_CYCLE_COUNTER_EN
  localparam logic [31:0] EXP_CYC10 = 32'd10;
`else
  localparam logic [31:0] EXP_CYC10 = 32'd0;
`endif

  dbg_run_ctrl #(.PC_WIDTH(32), .STEP_WIDTH(16), .CPU_RST_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_strobe (cmd_strobe),
    .cmd        (cmd),
    .cmd_arg    (cmd_arg),
    .pc         (pc),
    .cpu_clk_en (cpu_clk_en),
    .cpu_rst    (cpu_rst),
    .halted     (halted),
    .state      (state),
    .bp_hit     (bp_hit),
    .step_left  (step_left),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Tiny CPU model: pc advances by 4 on every enabled clock, looping in 32 bytes.
  always @(posedge clk) begin
    if (pc_set)          pc <= pc_set_val;
    else if (cpu_clk_en) pc <= (pc + 32'd4) & 32'h1F;
  end

  // Issue a command; returns on the negedge where its effect is first visible.
  task automatic issue(input logic [3:0] c, input logic [31:0] a);
    repeat (2) @(negedge clk);
    cmd = c;
    cmd_arg = a;
    cmd_strobe = 1'b1;
    repeat (3) @(negedge clk);
    cmd_strobe = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_set_val = v;
    pc_set = 1'b1;
    @(negedge clk);
    pc_set = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({state, cpu_clk_en, cpu_rst, bp_hit, halted} !== 6'b00_0001) begin
      fails++;
      $display("FAIL reset_flags: got st=%b en=%b rst=%b hit=%b halted=%b want 00 0 0 0 1",
               state, cpu_clk_en, cpu_rst, bp_hit, halted);
    end
    tests_run++;
    if (step_left !== 16'd0 || cycle_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_counts: got step_left=%0d cyc=%0d want 0 0", step_left, cycle_cnt);
    end
  endtask

  task automatic test_step5();
    int cnt = 0;
    int last = -1;
    @(negedge clk);
    cmd = 4'd3;
    cmd_arg = 32'd5;
    cmd_strobe = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (state !== 2'b00 || cpu_clk_en !== 1'b0) begin
      fails++;
      $display("FAIL step5_latency: after 2 edges st=%b en=%b want 00 0", state, cpu_clk_en);
    end
    @(negedge clk);
    cmd_strobe = 1'b0;
    tests_run++;
    if (state !== 2'b10 || step_left !== 16'd5 || cpu_clk_en !== 1'b1) begin
      fails++;
      $display("FAIL step5_start: got st=%b left=%0d en=%b want 10 5 1", state, step_left, cpu_clk_en);
    end
    for (int i = 0; i < 12; i++) begin
      if (cpu_clk_en === 1'b1) begin
        cnt++;
        last = i;
      end
      @(negedge clk);
    end
    tests_run++;
    if (cnt != 5 || last != 4) begin
      fails++;
      $display("FAIL step5_enables: got count=%0d last=%0d want 5 4", cnt, last);
    end
    tests_run++;
    if (state !== 2'b00 || halted !== 1'b1 || step_left !== 16'd0) begin
      fails++;
      $display("FAIL step5_end: got st=%b halted=%b left=%0d want 00 1 0", state, halted, step_left);
    end
  endtask

  task automatic test_step0();
    int cnt = 0;
    issue(4'd3, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (cpu_clk_en === 1'b1) cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt != 1 || state !== 2'b00) begin
      fails++;
      $display("FAIL step0: got count=%0d st=%b want 1 00", cnt, state);
    end
  endtask

  task automatic test_breakpoint();
    int cnt = 0;
    bit found = 0;
    set_pc(32'h0);
    issue(4'd4, 32'h10);
    issue(4'd2, 32'h0);
    for (int i = 0; i < 20 && !found; i++) begin
      if (cpu_clk_en === 1'b1) begin
        cnt++;
        @(negedge clk);
      end else found = 1;
    end
    tests_run++;
    if (!found || cnt != 4 || pc !== 32'h10) begin
      fails++;
      $display("FAIL bp_first_stop: got found=%0d count=%0d pc=%h want 1 4 00000010", found, cnt, pc);
    end
    @(negedge clk);
    tests_run++;
    if (state !== 2'b11 || bp_hit !== 1'b1 || halted !== 1'b1 || cpu_clk_en !== 1'b0) begin
      fails++;
      $display("FAIL bp_break_state: got st=%b hit=%b halted=%b en=%b want 11 1 1 0",
               state, bp_hit, halted, cpu_clk_en);
    end
    issue(4'd2, 32'h0);
    tests_run++;
    if (state !== 2'b01 || cpu_clk_en !== 1'b1 || pc !== 32'h10) begin
      fails++;
      $display("FAIL bp_resume: got st=%b en=%b pc=%h want 01 1 00000010", state, cpu_clk_en, pc);
    end
    cnt = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cpu_clk_en === 1'b1) begin
        cnt++;
        @(negedge clk);
      end else found = 1;
    end
    tests_run++;
    if (!found || cnt != 8 || pc !== 32'h10) begin
      fails++;
      $display("FAIL bp_second_stop: got found=%0d count=%0d pc=%h want 1 8 00000010", found, cnt, pc);
    end
    @(negedge clk);
    tests_run++;
    if (state !== 2'b11) begin
      fails++;
      $display("FAIL bp_second_state: got st=%b want 11", state);
    end
    issue(4'd5, 32'h0);
    tests_run++;
    if (bp_hit !== 1'b0 || state !== 2'b11) begin
      fails++;
      $display("FAIL bp_clear: got hit=%b st=%b want 0 11", bp_hit, state);
    end
    issue(4'd1, 32'h0);
    tests_run++;
    if (state !== 2'b00) begin
      fails++;
      $display("FAIL bp_halt: got st=%b want 00", state);
    end
  endtask

  task automatic test_reset_cpu();
    int cnt = 0;
    int en_seen = 0;
    issue(4'd2, 32'h0);
    tests_run++;
    if (state !== 2'b01 || cpu_clk_en !== 1'b1) begin
      fails++;
      $display("FAIL rstcpu_run: got st=%b en=%b want 01 1", state, cpu_clk_en);
    end
    issue(4'd6, 32'h0);
    tests_run++;
    if (cpu_rst !== 1'b1 || state !== 2'b00 || cycle_cnt !== 32'd0) begin
      fails++;
      $display("FAIL rstcpu_start: got rst=%b st=%b cyc=%0d want 1 00 0", cpu_rst, state, cycle_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      if (cpu_rst === 1'b1) cnt++;
      if (cpu_clk_en !== 1'b0) en_seen++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt != 4 || en_seen != 0) begin
      fails++;
      $display("FAIL rstcpu_pulse: got high=%0d en_cycles=%0d want 4 0", cnt, en_seen);
    end
  endtask

  task automatic test_held_strobe();
    int cnt = 0;
    @(negedge clk);
    cmd = 4'd3;
    cmd_arg = 32'd2;
    cmd_strobe = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (cpu_clk_en === 1'b1) cnt++;
      if (i == 19) cmd_strobe = 1'b0;
    end
    tests_run++;
    if (cnt != 2 || state !== 2'b00) begin
      fails++;
      $display("FAIL held_strobe: got count=%0d st=%b want 2 00", cnt, state);
    end
    issue(4'd2, 32'h0);
    issue(4'd9, 32'hFFFF);
    tests_run++;
    if (state !== 2'b01 || cpu_clk_en !== 1'b1) begin
      fails++;
      $display("FAIL unused_code: got st=%b en=%b want 01 1", state, cpu_clk_en);
    end
    issue(4'd1, 32'h0);
    tests_run++;
    if (state !== 2'b00 || cpu_clk_en !== 1'b0) begin
      fails++;
      $display("FAIL halt_cmd: got st=%b en=%b want 00 0", state, cpu_clk_en);
    end
  endtask

  task automatic test_rst_mid_step();
    issue(4'd4, 32'h1000);
    issue(4'd3, 32'd10);
    repeat (3) @(negedge clk);
    tests_run++;
    if (step_left !== 16'd7 || state !== 2'b10) begin
      fails++;
      $display("FAIL midstep_count: got left=%0d st=%b want 7 10", step_left, state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (state !== 2'b00 || step_left !== 16'd0 || cpu_clk_en !== 1'b0) begin
      fails++;
      $display("FAIL midstep_rst: got st=%b left=%0d en=%b want 00 0 0", state, step_left, cpu_clk_en);
    end
    set_pc(32'h1000);
    issue(4'd2, 32'h0);
    tests_run++;
    if (state !== 2'b01 || cpu_clk_en !== 1'b1) begin
      fails++;
      $display("FAIL bp_disabled_after_rst: got st=%b en=%b want 01 1", state, cpu_clk_en);
    end
    issue(4'd1, 32'h0);
  endtask

  task automatic test_cycle_counter();
    issue(4'd6, 32'h0);
    repeat (5) @(negedge clk);
    issue(4'd2, 32'h0);
    tests_run++;
    if (cycle_cnt !== 32'd0) begin
      fails++;
      $display("FAIL cyc_start: got %0d want 0", cycle_cnt);
    end
    repeat (5) @(negedge clk);
    issue(4'd1, 32'h0);
    tests_run++;
    if (state !== 2'b00 || cycle_cnt !== EXP_CYC10) begin
      fails++;
      $display("FAIL cyc_run10: got st=%b cyc=%0d want 00 %0d", state, cycle_cnt, EXP_CYC10);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (cycle_cnt !== EXP_CYC10) begin
      fails++;
      $display("FAIL cyc_hold: got %0d want %0d", cycle_cnt, EXP_CYC10);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_step5();
    test_step0();
    test_breakpoint();
    test_reset_cpu();
    test_held_strobe();
    test_rst_mid_step();
    test_cycle_counter();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
